// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_sync
//  Description : Two-flop synchroniser plus debounce FSM for a bouncy input;
//                emits a clean level and one-cycle rise/fall pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_sync #(
    parameter int STABLE = 8,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam logic [1:0] S_LOW_STABLE  = 2'd0;
    localparam logic [1:0] S_WAIT_HIGH   = 2'd1;
    localparam logic [1:0] S_HIGH_STABLE = 2'd2;
    localparam logic [1:0] S_WAIT_LOW    = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE - 1);

    if ((STABLE < 2) || (STABLE > ((2 ** CNT_W) - 1))) begin : g_param_check
        $fatal(1, "debounce_sync: STABLE must lie in 2..2**CNT_W-1");
    end

    logic             r_s1;
    logic             r_s2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= S_LOW_STABLE;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW_STABLE: begin
                    if (r_s2) begin
                        r_state <= S_WAIT_HIGH;
                        r_cnt   <= c_cnt_one;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    // A reversal drops back to the stable state so the full window restarts.
                    if (!r_s2) begin
                        r_state <= S_LOW_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= S_HIGH_STABLE;
                        r_dout  <= 1'b1;
                        r_rise  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                S_HIGH_STABLE: begin
                    if (!r_s2) begin
                        r_state <= S_WAIT_LOW;
                        r_cnt   <= c_cnt_one;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (r_s2) begin
                        r_state <= S_HIGH_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= S_LOW_STABLE;
                        r_dout  <= 1'b0;
                        r_fall  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_sync
//  Description : Self-checking bench for debounce_sync at three parameter sets
//                against a run-length reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_sync;

    logic       clk;
    logic       rst;
    logic       din;
    logic [2:0] dout;
    logic [2:0] rise;
    logic [2:0] fall;

    int checks = 0;
    int errors = 0;

    // Reference model: synchronised history and per-instance run length
    int   stab [3] = '{4, 2, 15};
    int   run  [3];
    logic [2:0] m_dout;
    logic [2:0] m_rise;
    logic [2:0] m_fall;
    logic h1, h2;

    debounce_sync #(.STABLE(4), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[0]), .rise(rise[0]), .fall(fall[0]));
    debounce_sync #(.STABLE(2), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[1]), .rise(rise[1]), .fall(fall[1]));
    debounce_sync #(.STABLE(15), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[2]), .rise(rise[2]), .fall(fall[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, advance the model past the edge, leave time at edge+1.
    task automatic tick(input logic d, input logic r);
        logic used;
        din = d;
        rst = r;
        @(posedge clk);
        #1;
        used = h2;
        for (int i = 0; i < 3; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (r) begin
                m_dout[i] = 1'b0;
                run[i]    = 0;
            end else if (used != m_dout[i]) begin
                run[i] = run[i] + 1;
                if (run[i] == stab[i]) begin
                    m_dout[i] = ~m_dout[i];
                    m_rise[i] = m_dout[i];
                    m_fall[i] = ~m_dout[i];
                    run[i]    = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        if (r) begin
            h1 = 1'b0;
            h2 = 1'b0;
        end else begin
            h2 = h1;
            h1 = d;
        end
    endtask

    task automatic test_reset;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++;
        if ({dout, rise, fall} !== 9'b0) begin
            errors++;
            $display("FAIL reset_values: got dout=%b rise=%b fall=%b, want all 0", dout, rise, fall);
        end
        for (int k = 1; k <= 7; k++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL reset_release_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         k, dout, rise, fall, m_dout, m_rise, m_fall);
            end
            if (k == 5 || k == 6 || k == 7) begin
                checks++;
                if (dout[0] !== (k >= 6) || rise[0] !== (k == 6)) begin
                    errors++;
                    $display("FAIL reset_release_edge%0d: got dout=%b rise=%b want dout=%b rise=%b",
                             k, dout[0], rise[0], (k >= 6), (k == 6));
                end
            end
        end
    endtask

    task automatic test_clean_press;
        int first;
        int nrise;
        int nfall;
        tick(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b0);
        first = -1; nrise = 0; nfall = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL clean_press_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         k, dout, rise, fall, m_dout, m_rise, m_fall);
            end
            if (dout[0] === 1'b1 && first < 0) first = k;
            if (rise[0] === 1'b1) nrise++;
            if (fall[0] === 1'b1) nfall++;
        end
        checks++;
        if (first != 6 || nrise != 1 || nfall != 0) begin
            errors++;
            $display("FAIL clean_press: got edge=%0d rises=%0d falls=%0d want 6/1/0", first, nrise, nfall);
        end
    endtask

    task automatic test_bounce;
        logic [6:0] pat;
        int first;
        int nrise;
        pat = 7'b1011011;  // bit 6 first: 1,0,1,1,0,1,1 reversed below
        tick(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b0);
        first = -1; nrise = 0;
        for (int k = 1; k <= 20; k++) begin
            // din sequence 1,1,0,1,1,0,1 then held 1
            tick((k <= 7) ? pat[k-1] : 1'b1, 1'b0);
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL bounce_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         k, dout, rise, fall, m_dout, m_rise, m_fall);
            end
            if (dout[0] === 1'b1 && first < 0) first = k;
            if (rise[0] === 1'b1) nrise++;
        end
        checks++;
        if (first != 12 || nrise != 1) begin
            errors++;
            $display("FAIL bounce_timing: got edge=%0d rises=%0d want 12/1", first, nrise);
        end
    endtask

    task automatic test_glitch;
        int nrise;
        int nfall;
        tick(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b0);
        nrise = 0;
        for (int k = 1; k <= 13; k++) begin
            tick(k <= 3, 1'b0);
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL glitch_high_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         k, dout, rise, fall, m_dout, m_rise, m_fall);
            end
            if (rise[0] === 1'b1 || dout[0] !== 1'b0) nrise++;
        end
        checks++;
        if (nrise != 0) begin
            errors++;
            $display("FAIL glitch_high: got %0d cycles with dout/rise high, want 0", nrise);
        end
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
        nfall = 0;
        for (int k = 1; k <= 13; k++) begin
            tick(k > 3, 1'b0);
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL glitch_low_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         k, dout, rise, fall, m_dout, m_rise, m_fall);
            end
            if (fall[0] === 1'b1 || dout[0] !== 1'b1) nfall++;
        end
        checks++;
        if (nfall != 0) begin
            errors++;
            $display("FAIL glitch_low: got %0d cycles with fall or dout low, want 0", nfall);
        end
    endtask

    task automatic test_release_and_reset;
        int first;
        int nfall;
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
        first = -1; nfall = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL release_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         k, dout, rise, fall, m_dout, m_rise, m_fall);
            end
            if (dout[0] === 1'b0 && first < 0) first = k;
            if (fall[0] === 1'b1) nfall++;
        end
        checks++;
        if (first != 6 || nfall != 1) begin
            errors++;
            $display("FAIL release: got edge=%0d falls=%0d want 6/1", first, nfall);
        end
        for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        checks++;
        if (dout[0] !== 1'b1) begin
            errors++;
            $display("FAIL wait_low_precondition: got dout=%b want 1", dout[0]);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (dout !== 3'b000 || fall !== 3'b000 || rise !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_wait_low: got dout=%b fall=%b rise=%b want 000/000/000", dout, fall, rise);
        end
    endtask

    task automatic test_param_sweep;
        int first [3];
        int nrise [3];
        int wide  [3];
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            first[i] = -1; nrise[i] = 0; wide[i] = 0;
        end
        for (int k = 1; k <= 22; k++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                errors++;
                $display("FAIL sweep_model edge %0d: got %b/%b/%b want %b/%b/%b",
                         k, dout, rise, fall, m_dout, m_rise, m_fall);
            end
            for (int i = 0; i < 3; i++) begin
                if (dout[i] === 1'b1 && first[i] < 0) first[i] = k;
                if (rise[i] === 1'b1) nrise[i]++;
                if (rise[i] === 1'b1 && first[i] != k) wide[i]++;
            end
        end
        checks++;
        if (first[0] != 6 || first[1] != 4 || first[2] != 17) begin
            errors++;
            $display("FAIL sweep_latency: got %0d/%0d/%0d want 6/4/17", first[0], first[1], first[2]);
        end
        checks++;
        if (nrise[0] != 1 || nrise[1] != 1 || nrise[2] != 1 || (wide[0] + wide[1] + wide[2]) != 0) begin
            errors++;
            $display("FAIL sweep_pulse_width: got rises %0d/%0d/%0d stray %0d want 1/1/1 stray 0",
                     nrise[0], nrise[1], nrise[2], wide[0] + wide[1] + wide[2]);
        end
    endtask

    task automatic test_random;
        logic lvl;
        int   hold;
        int   both;
        lvl  = 1'b0;
        both = 0;
        for (int seg = 0; seg < 60; seg++) begin
            lvl  = ~lvl;
            hold = $urandom_range(1, 20);
            for (int k = 0; k < hold; k++) begin
                tick(lvl, ($urandom_range(0, 199) == 0));
                checks++;
                if (dout !== m_dout || rise !== m_rise || fall !== m_fall) begin
                    errors++;
                    $display("FAIL random_model seg %0d: got %b/%b/%b want %b/%b/%b",
                             seg, dout, rise, fall, m_dout, m_rise, m_fall);
                end
                if ((rise & fall) != 3'b000) both++;
            end
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL rise_fall_exclusive: got %0d overlapping cycles want 0", both);
        end
    endtask

    initial begin
        din = 1'b0;
        rst = 1'b1;
        h1 = 1'b0;
        h2 = 1'b0;
        m_dout = '0;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < 3; i++) run[i] = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_and_reset();
        test_param_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
